mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares a single four-banked main memory between the instruction-cache controller (requester 0) and the data-cache controller (requester 1). It arbitrates each word access, honours multi-cycle burst locks so that line fills and write-backs are not interleaved, and checks bank availability before issuing. It also routes returning read data to the requester that issued it. It sits between both cache controllers and the memory macro.

## Interface

Parameters:
- RD_LAT, 2, cycles from read issue to valid mem_rdata; legal values 1-4.
- BANK_LSB, 1, lowest address bit of the 2-bit bank select, which is addr[BANK_LSB+1:BANK_LSB].

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset; the block is in reset while rst=0.
- req0_rd, req0_wr  in  1 each  requester 0 read or write request for this cycle.
- req0_lock  in  1  keep ownership after this access.
- req0_addr  in  16  word address for requester 0.
- req0_wdata  in  16  write data for requester 0.
- req1_rd, req1_wr, req1_lock, req1_addr, req1_wdata  in  1/1/1/16/16  same fields for requester 1.
- mem_busy  in  4  per-bank busy flags from memory.
- mem_rdata  in  16  read data from memory.
- mem_rd, mem_wr  out  1 each  memory strobes.
- mem_addr, mem_wdata  out  16 each  memory address and write data.
- gnt0, gnt1  out  1 each  the access from that requester is issued to memory this cycle.
- stall0, stall1  out  1 each  the requester has an active request that is not granted this cycle.
- rvalid0, rvalid1  out  1 each  rdata belongs to that requester this cycle.
- rdata  out  16  read data, equal to mem_rdata.

## Operation

- Request definition:
  - reqX = reqX_rd | reqX_wr.
  - If rd and wr are both 1 from the same requester, the access is a write and rd is ignored.
- Ownership FSM states:
  - FREE: no owner.
  - OWN0: requester 0 owns memory.
  - OWN1: requester 1 owns memory.
- Candidate selection:
  - In FREE with a single request, that requester is the candidate.
  - In FREE with both requesting, the round-robin pointer rr picks the candidate. rr=0 favours requester 0.
  - In OWNx, only requester x can be the candidate. The other requester is stalled unconditionally.
- Issue rule: the candidate is granted iff mem_busy[bank(candidate addr)]==0.
  - If the candidate's bank is busy, nothing issues that cycle.
  - The other requester is not tried in its place; there is no bypass.
- On grant:
  - mem_rd or mem_wr is driven to 1, with mem_addr and mem_wdata muxed from the winner.
  - rr is set to the opposite of the winner.
- FSM transitions, evaluated on each grant or idle cycle:
  - FREE → OWNx when x is granted with reqX_lock=1.
  - OWNx → FREE when x is granted with reqX_lock=0, which marks the last beat of a burst.
  - OWNx → FREE when x presents no request in a cycle, which releases an abandoned lock.
  - FREE → FREE when a grant carries lock=0.
- Idle outputs: when nothing is granted, mem_rd=mem_wr=0 and mem_addr=mem_wdata=0.
- Read return:
  - Each granted read pushes {1, id} into an RD_LAT-deep shift pipeline. Writes and idle cycles push {0, x}.
  - The pipeline output drives rvalid0 or rvalid1.
  - rdata is always mem_rdata.
  - Returns are never blocked; the cache controllers must accept them.
- Stall rule: stallX = reqX & ~gntX.

## Timing

- Grant is combinational: gntX, mem_rd, mem_wr, mem_addr and mem_wdata depend on the current state and the same-cycle inputs.
  - Grant latency is 0 cycles when the bank is free and ownership permits.
- FSM, rr and the return pipeline update on the rising clk edge.
- Read data latency: a read granted in cycle N gives rvalidX=1 in cycle N+RD_LAT. Back-to-back reads return back-to-back.
- Reset (rst=0), asynchronous:
  - FSM=FREE, rr=0, pipeline valid bits all cleared.
  - Combinational outputs still follow the inputs under FREE/rr=0 rules. They are 0 when no request is present.
  - rvalid0=rvalid1=0.
- Reset mid-burst:
  - Ownership is lost and in-flight read returns are discarded.
  - The first cycle after rst rises arbitrates from FREE.
- Same cycle as a FREE grant: if the loser's request is still present, it is serviced on the next opportunity because rr has flipped.
- Lock release and new grant: release from OWNx and a grant to the other requester cannot occur in the same cycle. The other requester's earliest grant is the cycle after release.

## Test plan

- Single read: req0_rd=1, addr=0x0010, banks free, RD_LAT=2.
  - Expect gnt0=1 and mem_rd=1 in cycle N.
  - Expect rvalid0=1 and rdata=mem_rdata in cycle N+2, with rvalid1=0.
- Contention: both requesters read every cycle from free banks, starting from reset.
  - Expect grants alternating 0,1,0,1.
  - The losing requester shows stall=1 in each cycle it loses.
- Burst lock: req1 issues 4 reads with lock=1,1,1,0 while req0 requests continuously.
  - Expect gnt0=0 and stall0=1 for all 4 cycles.
  - Expect FSM back in FREE after the 4th beat and gnt0=1 on the next cycle.
- Busy bank: req0_wr to addr 0x0004 (bank 2) with mem_busy=4'b0100 for 3 cycles, then 0.
  - Expect no memory strobe and stall0=1 for 3 cycles, then gnt0=1 and mem_wr=1.
  - Expect req1 not granted during those 3 cycles when rr=0.
- Abandoned lock: req0 granted with lock=1, then req0 idle for one cycle.
  - Expect FSM=FREE and req1 granted the following cycle.
- Async reset mid-read: a read is granted, then rst is pulled to 0 one cycle later.
  - Expect rvalid0=0 immediately and no return after rst rises.
  - Expect the pipeline empty and rr=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a four-banked main memory: round-robin word arbitration,
// burst ownership locks, per-bank busy gating and read-return routing.
module mem_arbiter #(
   parameter int RD_LAT   = 2,
   parameter int BANK_LSB = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_rd,
   input  logic        req0_wr,
   input  logic        req0_lock,
   input  logic [15:0] req0_addr,
   input  logic [15:0] req0_wdata,
   input  logic        req1_rd,
   input  logic        req1_wr,
   input  logic        req1_lock,
   input  logic [15:0] req1_addr,
   input  logic [15:0] req1_wdata,
   input  logic [3:0]  mem_busy,
   input  logic [15:0] mem_rdata,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        gnt0,
   output logic        gnt1,
   output logic        stall0,
   output logic        stall1,
   output logic        rvalid0,
   output logic        rvalid1,
   output logic [15:0] rdata,
   output logic [1:0]  dbg_state,
   output logic        dbg_rr
);

   // Handshake: a requester holds rd/wr (and addr/wdata/lock) while stallX=1; gntX=1 means
   // that beat was issued to memory this cycle and the requester may present its next beat.
   // Read data is pushed with rvalidX and cannot be back-pressured.

   typedef enum logic [1:0] {
      FREE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } own_e;

   own_e state_q, state_d;
   logic rr_q, rr_d;
   logic [RD_LAT-1:0] vld_pipe, id_pipe;

   logic        req0, req1;
   logic        cand_valid, cand_id;
   logic [15:0] cand_addr, cand_wdata;
   logic        cand_wr, cand_lock;
   logic [1:0]  cand_bank;
   logic        grant;

   assign req0 = req0_rd | req0_wr;
   assign req1 = req1_rd | req1_wr;

   always_comb begin
      cand_valid = 1'b0;
      cand_id    = 1'b0;
      unique case (state_q)
         FREE: begin
            if (req0 && req1) begin
               cand_valid = 1'b1;
               cand_id    = rr_q;
            end else if (req0 || req1) begin
               cand_valid = 1'b1;
               cand_id    = req1;
            end
         end
         OWN0: cand_valid = req0;
         OWN1: begin
            cand_valid = req1;
            cand_id    = 1'b1;
         end
         default: cand_valid = 1'b0;
      endcase
   end

   assign cand_addr  = cand_id ? req1_addr  : req0_addr;
   assign cand_wdata = cand_id ? req1_wdata : req0_wdata;
   assign cand_wr    = cand_id ? req1_wr    : req0_wr;
   assign cand_lock  = cand_id ? req1_lock  : req0_lock;
   assign cand_bank  = cand_addr[BANK_LSB+1:BANK_LSB];

   // No bypass: a blocked candidate blocks the whole cycle.
   assign grant = cand_valid & ~mem_busy[cand_bank];

   assign gnt0      = grant & ~cand_id;
   assign gnt1      = grant &  cand_id;
   assign mem_wr    = grant &  cand_wr;
   assign mem_rd    = grant & ~cand_wr;
   assign mem_addr  = grant ? cand_addr  : 16'h0000;
   assign mem_wdata = grant ? cand_wdata : 16'h0000;
   assign stall0    = req0 & ~gnt0;
   assign stall1    = req1 & ~gnt1;

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      if (grant) rr_d = ~cand_id;
      unique case (state_q)
         FREE: if (grant && cand_lock) state_d = cand_id ? OWN1 : OWN0;
         OWN0: if (!req0 || (gnt0 && !req0_lock)) state_d = FREE;
         OWN1: if (!req1 || (gnt1 && !req1_lock)) state_d = FREE;
         default: state_d = FREE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FREE;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
      end
   end

   // Return pipeline: stage 0 is loaded at issue, stage RD_LAT-1 is the return cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe[0] <= mem_rd;
         id_pipe[0]  <= gnt1;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            id_pipe[i]  <= id_pipe[i-1];
         end
      end
   end

   assign rvalid0   = vld_pipe[RD_LAT-1] & ~id_pipe[RD_LAT-1];
   assign rvalid1   = vld_pipe[RD_LAT-1] &  id_pipe[RD_LAT-1];
   assign rdata     = mem_rdata;
   assign dbg_state = state_q;
   assign dbg_rr    = rr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against an ownership/round-robin reference model.
module tb_mem_arbiter;

   localparam int RD_LAT   = 2;
   localparam int BANK_LSB = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req0_rd = 0, req0_wr = 0, req0_lock = 0;
   logic [15:0] req0_addr = '0, req0_wdata = '0;
   logic        req1_rd = 0, req1_wr = 0, req1_lock = 0;
   logic [15:0] req1_addr = '0, req1_wdata = '0;
   logic [3:0]  mem_busy = '0;
   logic [15:0] mem_rdata = '0;
   logic        mem_rd, mem_wr, gnt0, gnt1, stall0, stall1, rvalid0, rvalid1, dbg_rr;
   logic [15:0] mem_addr, mem_wdata, rdata;
   logic [1:0]  dbg_state;

   mem_arbiter #(.RD_LAT(RD_LAT), .BANK_LSB(BANK_LSB)) dut (
      .clk(clk), .rst(rst),
      .req0_rd(req0_rd), .req0_wr(req0_wr), .req0_lock(req0_lock),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_rd(req1_rd), .req1_wr(req1_wr), .req1_lock(req1_lock),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .mem_busy(mem_busy), .mem_rdata(mem_rdata),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .gnt0(gnt0), .gnt1(gnt1), .stall0(stall0), .stall1(stall1),
      .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
      .dbg_state(dbg_state), .dbg_rr(dbg_rr)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: owner -1 = nobody, else requester id; returns keyed by cycle number
   int owner = -1;
   int rr    = 0;
   int cyc   = 0;
   int ret_id[int];
   int exp_gnt;
   logic exp_rd;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic int bank_of(input logic [15:0] a);
      return int'((a >> BANK_LSB) & 16'h3);
   endfunction

   task automatic model_clear();
      owner = -1;
      rr    = 0;
      ret_id.delete();
   endtask

   task automatic check_outputs();
      logic r0, r1, e_wr;
      int cand;
      logic [15:0] e_addr, e_wdata;
      r0 = req0_rd | req0_wr;
      r1 = req1_rd | req1_wr;
      cand = -1;
      if (owner < 0) begin
         if (r0 && r1) cand = rr;
         else if (r0)  cand = 0;
         else if (r1)  cand = 1;
      end else if (owner == 0 && r0) cand = 0;
      else if (owner == 1 && r1) cand = 1;
      exp_gnt = -1;
      if (cand >= 0 && !mem_busy[bank_of(cand == 1 ? req1_addr : req0_addr)]) exp_gnt = cand;
      e_wr    = (exp_gnt == 0 && req0_wr) || (exp_gnt == 1 && req1_wr);
      exp_rd  = (exp_gnt >= 0) && !e_wr;
      e_addr  = exp_gnt == 0 ? req0_addr  : exp_gnt == 1 ? req1_addr  : 16'h0;
      e_wdata = exp_gnt == 0 ? req0_wdata : exp_gnt == 1 ? req1_wdata : 16'h0;
      check("gnt0", 16'(gnt0), 16'(exp_gnt == 0));
      check("gnt1", 16'(gnt1), 16'(exp_gnt == 1));
      check("stall0", 16'(stall0), 16'(r0 && exp_gnt != 0));
      check("stall1", 16'(stall1), 16'(r1 && exp_gnt != 1));
      check("mem_rd", 16'(mem_rd), 16'(exp_rd));
      check("mem_wr", 16'(mem_wr), 16'(e_wr));
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      check("rvalid0", 16'(rvalid0), 16'(ret_id.exists(cyc) && ret_id[cyc] == 0));
      check("rvalid1", 16'(rvalid1), 16'(ret_id.exists(cyc) && ret_id[cyc] == 1));
      check("rdata", rdata, mem_rdata);
      check("state", 16'(dbg_state), owner < 0 ? 16'd0 : owner == 0 ? 16'd1 : 16'd2);
      check("rr", 16'(dbg_rr), 16'(rr));
   endtask

   task automatic model_update();
      int lk;
      logic own_req;
      if (!rst) return;
      if (exp_gnt >= 0) begin
         if (exp_rd) ret_id[cyc + RD_LAT] = exp_gnt;
         rr = 1 - exp_gnt;
         lk = exp_gnt == 1 ? int'(req1_lock) : int'(req0_lock);
         if (owner < 0 && lk != 0) owner = exp_gnt;
         else if (owner == exp_gnt && lk == 0) owner = -1;
      end else if (owner >= 0) begin
         own_req = owner == 1 ? (req1_rd | req1_wr) : (req0_rd | req0_wr);
         if (!own_req) owner = -1;
      end
   endtask

   // driver tasks: inputs change on the falling edge, outputs checked 1ns later
   task automatic tick();
      mem_rdata = 16'($urandom);
      #1 check_outputs();
      @(posedge clk);
      model_update();
      cyc++;
      @(negedge clk);
   endtask

   task automatic set0(input logic rd, input logic wr, input logic lk, input logic [15:0] a);
      req0_rd = rd; req0_wr = wr; req0_lock = lk; req0_addr = a; req0_wdata = 16'($urandom);
   endtask

   task automatic set1(input logic rd, input logic wr, input logic lk, input logic [15:0] a);
      req1_rd = rd; req1_wr = wr; req1_lock = lk; req1_addr = a; req1_wdata = 16'($urandom);
   endtask

   task automatic idle_all();
      set0(0, 0, 0, 16'h0);
      set1(0, 0, 0, 16'h0);
      mem_busy = 4'h0;
   endtask

   // reset asserted asynchronously mid-cycle, held across one rising edge
   task automatic pulse_reset();
      rst = 1'b0;
      model_clear();
      tick();
      rst = 1'b1;
   endtask

   task automatic rand_req(input int id);
      logic r, rd, wr, lk;
      r  = $urandom_range(0, 9) < 7;
      wr = r && $urandom_range(0, 2) == 0;
      rd = r && (!wr || $urandom_range(0, 1) == 0);
      if (r && !wr) rd = 1'b1;
      lk = $urandom_range(0, 2) != 0;
      if (id == 0) set0(rd, wr, lk, 16'($urandom));
      else         set1(rd, wr, lk, 16'($urandom));
   endtask

   initial begin
      @(negedge clk);
      idle_all();
      model_clear();
      tick();
      rst = 1'b1;

      // single read, then observe its return
      set0(1, 0, 0, 16'h0010);
      tick();
      idle_all();
      repeat (3) tick();

      // contention from reset: alternating grants
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         set0(1, 0, 0, 16'(i * 2));
         set1(1, 0, 0, 16'(i * 2 + 8));
         tick();
      end
      idle_all();
      repeat (2) tick();

      // burst lock by requester 1 while requester 0 keeps requesting
      pulse_reset();
      set0(1, 0, 0, 16'h0000);
      tick();
      for (int i = 0; i < 4; i++) begin
         set0(1, 0, 0, 16'h0002);
         set1(1, 0, i < 3, 16'(16'h0100 + i));
         tick();
      end
      set1(0, 0, 0, 16'h0);
      tick();
      idle_all();
      repeat (2) tick();

      // busy bank blocks candidate, no bypass for the other requester
      pulse_reset();
      set0(0, 1, 0, 16'h0004);
      set1(1, 0, 0, 16'h0000);
      mem_busy = 4'b0100;
      repeat (3) tick();
      mem_busy = 4'b0000;
      tick();
      idle_all();
      repeat (3) tick();

      // abandoned lock
      pulse_reset();
      set0(1, 0, 1, 16'h0020);
      tick();
      set0(0, 0, 0, 16'h0);
      set1(1, 0, 0, 16'h0030);
      tick();
      tick();
      idle_all();
      repeat (2) tick();

      // reset one cycle after a read grant; the return must vanish
      set0(1, 0, 0, 16'h0040);
      tick();
      idle_all();
      pulse_reset();
      repeat (4) tick();

      // randomized traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         rand_req(0);
         rand_req(1);
         mem_busy = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) : 4'h0;
         if ($urandom_range(0, 199) == 0) pulse_reset();
         else tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

endmodule
